// File: rtl/muxn_scan.sv
// ---------------------------------------------------------------------------
// muxn_scan
//
// N-to-1 channel multiplexer with a one-entry registered output stage.
// Two grant policies are available, chosen combinationally by `mode`:
//   mode = 0 : manual select. Only channel `sel` may transfer.
//   mode = 1 : round-robin scan. The first requesting channel at or after
//              the scan pointer (wrapping) wins, and the pointer then moves
//              to the channel just after the winner.
//
// Parameters
//   WIDTH : data bits per channel (>= 1)
//   NCH   : number of input channels (2..16)
//   SELW  : derived channel index width, max(1, ceil(log2(NCH)))
//
// Ports
//   clk       : clock, all state updates on the rising edge
//   rst_n     : asynchronous active-low reset
//   mode      : 0 = manual select, 1 = round-robin scan
//   sel       : channel to forward in manual mode
//   in_data   : packed channel words, channel i at [i*WIDTH +: WIDTH]
//   in_valid  : per-channel data-valid
//   in_ready  : per-channel accept, at most one bit high
//   out_data  : registered word of the last transfer
//   out_ch    : channel index that produced out_data
//   out_valid : out_data/out_ch hold a word
//   out_ready : downstream accepts the held word when high with out_valid
// ---------------------------------------------------------------------------
module muxn_scan #(
    parameter int WIDTH = 8,
    parameter int NCH   = 4,
    localparam int SELW = (NCH > 2) ? $clog2(NCH) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 mode,
    input  logic [SELW-1:0]      sel,
    input  logic [NCH*WIDTH-1:0] in_data,
    input  logic [NCH-1:0]       in_valid,
    output logic [NCH-1:0]       in_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic [SELW-1:0]      out_ch,
    output logic                 out_valid,
    input  logic                 out_ready
);

    // Scan pointer: the channel the round-robin search starts from.
    logic [SELW-1:0] ptr;

    // Output register can take a new word when empty or being drained.
    logic accept;

    // Manual-mode grant.
    logic            man_hit;

    // Scan-mode grant.
    logic            scan_hit;
    logic [SELW-1:0] scan_idx;
    int              scan_best;
    int              scan_dist;

    // Selected grant for the current cycle.
    logic            grant_hit;
    logic [SELW-1:0] grant_idx;
    logic [WIDTH-1:0] grant_word;

    // A transfer completes on the granted channel this cycle.
    logic            xfer;
    logic [SELW-1:0] ptr_next;

    assign accept = !out_valid || out_ready;

    // Out-of-range select values (possible when NCH is not a power of two)
    // produce no grant at all.
    assign man_hit = (int'(sel) < NCH);

    // Round-robin search expressed as "closest requester ahead of ptr":
    // each requesting channel's distance from ptr (modulo NCH) is computed
    // and the smallest distance wins. This keeps every channel index a
    // constant, avoiding variable bit-selects on in_valid.
    always_comb begin
        scan_hit  = 1'b0;
        scan_idx  = '0;
        scan_best = NCH;
        scan_dist = 0;
        for (int i = 0; i < NCH; i++) begin
            scan_dist = (i + NCH - int'(ptr)) % NCH;
            if (in_valid[i] && (scan_dist < scan_best)) begin
                scan_best = scan_dist;
                scan_idx  = SELW'(i);
                scan_hit  = 1'b1;
            end
        end
    end

    // The grant depends on in_valid only in scan mode; in manual mode the
    // granted channel's ready never looks at its own valid.
    always_comb begin
        if (mode) begin
            grant_hit = scan_hit;
            grant_idx = scan_idx;
        end else begin
            grant_hit = man_hit;
            grant_idx = sel;
        end
    end

    // One-hot ready on the granted channel, suppressed while the output
    // register is full and stalled, and held low throughout reset.
    always_comb begin
        in_ready = '0;
        for (int i = 0; i < NCH; i++) begin
            if (rst_n && accept && grant_hit && (grant_idx == SELW'(i))) begin
                in_ready[i] = 1'b1;
            end
        end
    end

    // Word of the granted channel.
    always_comb begin
        grant_word = '0;
        for (int i = 0; i < NCH; i++) begin
            if (grant_idx == SELW'(i)) begin
                grant_word = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    assign xfer = |(in_ready & in_valid);

    // Pointer advances to the channel after the winner, wrapping explicitly
    // at NCH-1 so non-power-of-two channel counts stay in range.
    assign ptr_next = (grant_idx == SELW'(NCH - 1)) ? '0 : grant_idx + SELW'(1);

    // Output register and scan pointer. A transfer while the held word is
    // draining simply replaces it, so back-to-back words leave no bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data  <= '0;
            out_ch    <= '0;
            out_valid <= 1'b0;
            ptr       <= '0;
        end else begin
            if (xfer) begin
                out_data  <= grant_word;
                out_ch    <= grant_idx;
                out_valid <= 1'b1;
                if (mode) begin
                    ptr <= ptr_next;
                end
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    // At most one channel is ever offered a grant.
    a_ready_onehot : assert property (@(posedge clk) disable iff (!rst_n) $onehot0(in_ready));

endmodule
